// File: rtl/hex_pkg.sv
// Shared definitions for the paged hexadecimal display controller.
//   SEG_LUT    : active-low 7-segment codes for 0..F, bit order g..a
//   page_count : number of NDIG-digit pages needed to show a W-bit word
//   idx_w      : index width for n items, never less than 1
//   nav_e      : navigation action chosen for the current cycle
package hex_pkg;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int page_count(input int w, input int ndig);
    return (w / 4 + ndig - 1) / ndig;
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    NAV_HOLD,
    NAV_PAGE,
    NAV_CHAN,
    NAV_STEP
  } nav_e;

endpackage

// File: rtl/hex_pager_if.sv
// Board-side signal bundle of hex_pager.
//   DIN      : CH packed channel words, channel c at [c*W +: W]
//   NEXT_CH  : one-cycle pulse, advance channel
//   NEXT_PG  : one-cycle pulse, advance page
//   MODE     : 0 manual, 1 auto-scroll
//   BLANK    : leading-zero blanking enable
//   FREEZE   : hold a snapshot of DIN
//   CH_IDX   : displayed channel
//   PAGE_IDX : displayed page
//   nHEX     : active-low segments, digit d at [8d+7:8d], bit 7 = DP
// master drives the inputs (board top / bench), slave is the pager.
interface hex_pager_if #(
  parameter int NDIG = 6,
  parameter int CH   = 2,
  parameter int W    = 32
) ();

  localparam int CW = hex_pkg::idx_w(CH);
  localparam int PW = hex_pkg::idx_w(hex_pkg::page_count(W, NDIG));

  logic [CH*W-1:0]   DIN;
  logic              NEXT_CH;
  logic              NEXT_PG;
  logic              MODE;
  logic              BLANK;
  logic              FREEZE;
  logic [CW-1:0]     CH_IDX;
  logic [PW-1:0]     PAGE_IDX;
  logic [NDIG*8-1:0] nHEX;

  modport master (
    output DIN, NEXT_CH, NEXT_PG, MODE, BLANK, FREEZE,
    input  CH_IDX, PAGE_IDX, nHEX
  );

  modport slave (
    input  DIN, NEXT_CH, NEXT_PG, MODE, BLANK, FREEZE,
    output CH_IDX, PAGE_IDX, nHEX
  );

endinterface

// File: rtl/hex_pager_seg7_enc.sv
// seg7_enc: one digit of the display.
//   nib   : hex nibble to show
//   blank : 1 turns all seven segments off
//   dp    : 1 lights the decimal point
//   code  : active-low {DP, g..a}
module seg7_enc
  import hex_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] code
);

  assign code = {~dp, blank ? 7'h7F : SEG_LUT[nib]};

endmodule

// File: rtl/hex_pager.sv
// hex_pager: paged multi-channel hex display controller.
// Shows one NDIG-digit page of one channel word, with button or timed
// navigation, leading-zero blanking and a freeze snapshot.
//   CLK : system clock, rising edge
//   RST : asynchronous active-low reset
//   bus : hex_pager_if.slave (DIN, buttons, MODE, BLANK, FREEZE in;
//         CH_IDX, PAGE_IDX, nHEX out)
module hex_pager
  import hex_pkg::*;
#(
  parameter int NDIG     = 6,
  parameter int CH       = 2,
  parameter int W        = 32,
  parameter int AUTO_DIV = 50_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  hex_pager_if.slave  bus
);

  localparam int P    = page_count(W, NDIG);
  localparam int NIB  = W / 4;
  localparam int CW   = idx_w(CH);
  localparam int PW   = idx_w(P);
  localparam int CNTW = idx_w(AUTO_DIV);

  logic [CW-1:0]     ch_q;
  logic [PW-1:0]     pg_q;
  logic [CNTW-1:0]   cnt_q;
  logic              mode_q;
  logic              frz_q;
  logic [CH*W-1:0]   snap_q;

  logic              frz_rise;
  logic              mode_chg;
  logic              btn;
  logic              tc;
  nav_e              nav;
  logic              pg_wrap;
  logic [PW-1:0]     pg_nxt;
  logic [CW-1:0]     ch_nxt;

  assign frz_rise = bus.FREEZE & ~frz_q;
  assign mode_chg = bus.MODE ^ mode_q;
  assign btn      = bus.NEXT_CH | bus.NEXT_PG;
  assign tc       = bus.MODE & ~mode_chg & (cnt_q == CNTW'(AUTO_DIV - 1));

  // Buttons outrank the timer step; NEXT_CH outranks NEXT_PG.
  always_comb begin
    nav = NAV_HOLD;
    if (bus.NEXT_CH)      nav = NAV_CHAN;
    else if (bus.NEXT_PG) nav = NAV_PAGE;
    else if (tc)          nav = NAV_STEP;
  end

  always_comb begin
    pg_wrap = (pg_q == PW'(P - 1));
    pg_nxt  = pg_wrap ? '0 : pg_q + PW'(1);
    ch_nxt  = (CH == 1 || ch_q == CW'(CH - 1)) ? '0 : ch_q + CW'(1);
  end

  // mode_q leaves reset at 1: in manual mode the counter is held at 0
  // anyway, and in auto mode this keeps the first post-reset step exactly
  // AUTO_DIV cycles after release instead of spending a cycle on a
  // spurious mode-change clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ch_q   <= '0;
      pg_q   <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b1;
      frz_q  <= 1'b0;
      snap_q <= '0;
    end else begin
      mode_q <= bus.MODE;
      frz_q  <= bus.FREEZE;
      if (frz_rise) snap_q <= bus.DIN;
      case (nav)
        NAV_CHAN: begin
          ch_q <= ch_nxt;
          pg_q <= '0;
        end
        NAV_PAGE: pg_q <= pg_nxt;
        NAV_STEP: begin
          pg_q <= pg_nxt;
          if (pg_wrap) ch_q <= ch_nxt;
        end
        default: ;
      endcase
      if (btn || mode_chg || !bus.MODE || tc) cnt_q <= '0;
      else                                    cnt_q <= cnt_q + CNTW'(1);
    end
  end

  // ---- stage p0: select word, compute blanking prefix, encode digits ----
  // On the capture cycle the snapshot is not loaded yet, so show live DIN.
  logic [CH*W-1:0]   src;
  logic [W-1:0]      word;
  logic [NIB-1:0]    nz_from;
  logic [3:0]        nib_p0   [NDIG];
  logic              blank_p0 [NDIG];
  logic              dp_p0    [NDIG];
  logic [NDIG*8-1:0] seg_p0;

  assign src = (bus.FREEZE && !frz_rise) ? snap_q : bus.DIN;

  always_comb begin
    word = '0;
    for (int c = 0; c < CH; c++)
      if (ch_q == CW'(c)) word = src[c*W +: W];
  end

  // nz_from[k] is set when nibble k or any more-significant nibble is non-zero.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    nz_from = '0;
    for (int k = NIB - 1; k >= 0; k--) begin
      acc        = acc | (|word[4*k +: 4]);
      nz_from[k] = acc;
    end
  end

  // Digits whose nibble index falls past the word keep the fully-off default.
  always_comb begin
    for (int d = 0; d < NDIG; d++) begin
      nib_p0[d]   = '0;
      blank_p0[d] = 1'b1;
      dp_p0[d]    = 1'b0;
      for (int k = 0; k < NIB; k++) begin
        if (k == int'(pg_q) * NDIG + d) begin
          nib_p0[d]   = word[4*k +: 4];
          blank_p0[d] = bus.BLANK && (k != 0) && !nz_from[k];
          dp_p0[d]    = (d == NDIG - 1) && bus.FREEZE;
        end
      end
    end
  end

  for (genvar d = 0; d < NDIG; d++) begin : g_dig
    seg7_enc u_enc (
      .nib   (nib_p0[d]),
      .blank (blank_p0[d]),
      .dp    (dp_p0[d]),
      .code  (seg_p0[8*d +: 8])
    );
  end

  // ---- stage p1: registered segment outputs ----
  logic [NDIG*8-1:0] nhex_p1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) nhex_p1 <= '1;
    else      nhex_p1 <= seg_p0;
  end

  assign bus.nHEX     = nhex_p1;
  assign bus.CH_IDX   = ch_q;
  assign bus.PAGE_IDX = pg_q;

endmodule

// File: tb/tb_hex_pager.sv
module tb_hex_pager;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hex_pager_if #(.NDIG(4), .CH(2), .W(32)) bus ();

  hex_pager #(.NDIG(4), .CH(2), .W(32), .AUTO_DIV(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.DIN = {32'hDEAD_BEEF, 32'h0000_1234};
    bus.NEXT_CH = 1'b0; bus.NEXT_PG = 1'b0; bus.MODE = 1'b0;
    bus.BLANK = 1'b0; bus.FREEZE = 1'b0;
    rst = 1'b0;
    step(2);
    checks++;
    if (bus.nHEX !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL reset_nhex got=%h exp=%h", bus.nHEX, 32'hFFFF_FFFF);
    end
    checks++;
    if (bus.CH_IDX !== 1'b0 || bus.PAGE_IDX !== 1'b0) begin
      failures++; $display("FAIL reset_idx got=%0d/%0d exp=0/0", bus.CH_IDX, bus.PAGE_IDX);
    end
    rst = 1'b1;
    step(1);
    checks++;
    if (bus.nHEX !== 32'hF9A4_B099) begin
      failures++; $display("FAIL first_page got=%h exp=%h", bus.nHEX, 32'hF9A4_B099);
    end
  endtask

  task automatic test_paging;
    bus.NEXT_PG = 1'b1;
    step(1);
    bus.NEXT_PG = 1'b0;
    checks++;
    if (bus.PAGE_IDX !== 1'b1) begin
      failures++; $display("FAIL page_inc got=%0d exp=1", bus.PAGE_IDX);
    end
    step(1);
    checks++;
    if (bus.nHEX !== 32'hC0C0_C0C0) begin
      failures++; $display("FAIL page1_zeros got=%h exp=%h", bus.nHEX, 32'hC0C0_C0C0);
    end
    bus.BLANK = 1'b1;
    step(1);
    checks++;
    if (bus.nHEX !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL page1_blank got=%h exp=%h", bus.nHEX, 32'hFFFF_FFFF);
    end
    bus.NEXT_PG = 1'b1;
    step(1);
    bus.NEXT_PG = 1'b0;
    checks++;
    if (bus.PAGE_IDX !== 1'b0) begin
      failures++; $display("FAIL page_wrap got=%0d exp=0", bus.PAGE_IDX);
    end
    bus.DIN[31:0] = 32'h0000_0005;
    step(1);
    checks++;
    if (bus.nHEX !== 32'hFFFF_FF92) begin
      failures++; $display("FAIL blank_lead got=%h exp=%h", bus.nHEX, 32'hFFFF_FF92);
    end
  endtask

  task automatic test_simultaneous;
    bus.BLANK = 1'b0;
    bus.NEXT_CH = 1'b1; bus.NEXT_PG = 1'b1;
    step(1);
    bus.NEXT_CH = 1'b0; bus.NEXT_PG = 1'b0;
    checks++;
    if (bus.CH_IDX !== 1'b1 || bus.PAGE_IDX !== 1'b0) begin
      failures++; $display("FAIL both_btn_idx got=%0d/%0d exp=1/0", bus.CH_IDX, bus.PAGE_IDX);
    end
    step(1);
    checks++;
    if (bus.nHEX !== 32'h8386_868E) begin
      failures++; $display("FAIL beef got=%h exp=%h", bus.nHEX, 32'h8386_868E);
    end
  endtask

  task automatic test_auto_scroll;
    // back to ch0 page 0 in manual mode
    bus.NEXT_CH = 1'b1;
    step(1);
    bus.NEXT_CH = 1'b0;
    bus.DIN[31:0] = 32'h0000_1234;
    bus.MODE = 1'b1;
    // edge 1 clears the counter on the mode change; step lands on edge 9
    step(8);
    checks++;
    if (bus.CH_IDX !== 1'b0 || bus.PAGE_IDX !== 1'b0) begin
      failures++; $display("FAIL auto_pre got=%0d/%0d exp=0/0", bus.CH_IDX, bus.PAGE_IDX);
    end
    step(1);
    checks++;
    if (bus.CH_IDX !== 1'b0 || bus.PAGE_IDX !== 1'b1) begin
      failures++; $display("FAIL auto_s1 got=%0d/%0d exp=0/1", bus.CH_IDX, bus.PAGE_IDX);
    end
    step(7);
    checks++;
    if (bus.CH_IDX !== 1'b0 || bus.PAGE_IDX !== 1'b1) begin
      failures++; $display("FAIL auto_hold got=%0d/%0d exp=0/1", bus.CH_IDX, bus.PAGE_IDX);
    end
    step(1);
    checks++;
    if (bus.CH_IDX !== 1'b1 || bus.PAGE_IDX !== 1'b0) begin
      failures++; $display("FAIL auto_s2 got=%0d/%0d exp=1/0", bus.CH_IDX, bus.PAGE_IDX);
    end
    step(8);
    checks++;
    if (bus.CH_IDX !== 1'b1 || bus.PAGE_IDX !== 1'b1) begin
      failures++; $display("FAIL auto_s3 got=%0d/%0d exp=1/1", bus.CH_IDX, bus.PAGE_IDX);
    end
    step(1);
    checks++;
    if (bus.nHEX !== 32'hA186_88A1) begin
      failures++; $display("FAIL dead got=%h exp=%h", bus.nHEX, 32'hA186_88A1);
    end
    step(7);
    checks++;
    if (bus.CH_IDX !== 1'b0 || bus.PAGE_IDX !== 1'b0) begin
      failures++; $display("FAIL auto_s4 got=%0d/%0d exp=0/0", bus.CH_IDX, bus.PAGE_IDX);
    end
    // counter reaches 7 after 7 more edges; button collides with the step
    step(7);
    bus.NEXT_PG = 1'b1;
    step(1);
    bus.NEXT_PG = 1'b0;
    checks++;
    if (bus.CH_IDX !== 1'b0 || bus.PAGE_IDX !== 1'b1) begin
      failures++; $display("FAIL tc_collide got=%0d/%0d exp=0/1", bus.CH_IDX, bus.PAGE_IDX);
    end
    step(7);
    checks++;
    if (bus.CH_IDX !== 1'b0 || bus.PAGE_IDX !== 1'b1) begin
      failures++; $display("FAIL tc_restart_hold got=%0d/%0d exp=0/1", bus.CH_IDX, bus.PAGE_IDX);
    end
    step(1);
    checks++;
    if (bus.CH_IDX !== 1'b1 || bus.PAGE_IDX !== 1'b0) begin
      failures++; $display("FAIL tc_restart_step got=%0d/%0d exp=1/0", bus.CH_IDX, bus.PAGE_IDX);
    end
  endtask

  task automatic test_freeze;
    bus.MODE = 1'b0;
    bus.NEXT_CH = 1'b1;
    step(1);
    bus.NEXT_CH = 1'b0;
    checks++;
    if (bus.CH_IDX !== 1'b0 || bus.PAGE_IDX !== 1'b0) begin
      failures++; $display("FAIL frz_setup got=%0d/%0d exp=0/0", bus.CH_IDX, bus.PAGE_IDX);
    end
    step(1);
    bus.FREEZE = 1'b1;
    step(1);
    checks++;
    if (bus.nHEX !== 32'h79A4_B099) begin
      failures++; $display("FAIL frz_dp got=%h exp=%h", bus.nHEX, 32'h79A4_B099);
    end
    bus.DIN[31:0] = 32'h9999_9999;
    step(2);
    checks++;
    if (bus.nHEX !== 32'h79A4_B099) begin
      failures++; $display("FAIL frz_hold got=%h exp=%h", bus.nHEX, 32'h79A4_B099);
    end
    bus.FREEZE = 1'b0;
    step(1);
    checks++;
    if (bus.nHEX !== 32'h9090_9090) begin
      failures++; $display("FAIL frz_release got=%h exp=%h", bus.nHEX, 32'h9090_9090);
    end
  endtask

  task automatic test_reset_mid_scroll;
    bus.MODE = 1'b1;
    bus.NEXT_CH = 1'b1;
    step(1);
    bus.NEXT_CH = 1'b0;
    bus.NEXT_PG = 1'b1;
    step(1);
    bus.NEXT_PG = 1'b0;
    checks++;
    if (bus.CH_IDX !== 1'b1 || bus.PAGE_IDX !== 1'b1) begin
      failures++; $display("FAIL mid_setup got=%0d/%0d exp=1/1", bus.CH_IDX, bus.PAGE_IDX);
    end
    step(2);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.nHEX !== 32'hFFFF_FFFF || bus.CH_IDX !== 1'b0 || bus.PAGE_IDX !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%h %0d/%0d exp=ffffffff 0/0", bus.nHEX, bus.CH_IDX, bus.PAGE_IDX);
    end
    step(2);
    rst = 1'b1;
    step(1);
    checks++;
    if (bus.nHEX !== 32'h9090_9090) begin
      failures++; $display("FAIL post_reset_page got=%h exp=%h", bus.nHEX, 32'h9090_9090);
    end
    step(6);
    checks++;
    if (bus.CH_IDX !== 1'b0 || bus.PAGE_IDX !== 1'b0) begin
      failures++; $display("FAIL post_reset_hold got=%0d/%0d exp=0/0", bus.CH_IDX, bus.PAGE_IDX);
    end
    step(1);
    checks++;
    if (bus.CH_IDX !== 1'b0 || bus.PAGE_IDX !== 1'b1) begin
      failures++; $display("FAIL post_reset_step got=%0d/%0d exp=0/1", bus.CH_IDX, bus.PAGE_IDX);
    end
  endtask

  initial begin
    test_reset();
    test_paging();
    test_simultaneous();
    test_auto_scroll();
    test_freeze();
    test_reset_mid_scroll();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_pager.md
# hex_pager

Parametrised, paged multi-channel hexadecimal display controller for the board top level. It is the successor to the fixed per-digit 7-segment wiring. It takes CH data words of W bits, shows one NDIG-digit page of one channel at a time, and provides:
- button-driven or timer-driven (auto-scroll) channel/page navigation;
- optional leading-zero blanking;
- a freeze snapshot.

It sits between the debounced button pulses and the HEX pins; the channel/page indices feed the LEDs.

## Interface
Parameters:
- NDIG, 6, number of 7-segment digits driven
- CH, 2, number of input channels (e.g. PC, Result)
- W, 32, bits per channel word; multiple of 4
- AUTO_DIV, 50_000_000, clock cycles per auto-scroll step (≥2)

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- DIN  in  CH*W  channel words, channel c at DIN[c*W+W-1:c*W]
- NEXT_CH  in  1  one-cycle pulse: advance channel
- NEXT_PG  in  1  one-cycle pulse: advance page
- MODE  in  1  0 manual, 1 auto-scroll
- BLANK  in  1  1 enables leading-zero blanking
- FREEZE  in  1  1 holds a snapshot of DIN
- CH_IDX  out  max(1,$clog2(CH))  displayed channel
- PAGE_IDX  out  max(1,$clog2(P))  displayed page, P = ceil(W/(4*NDIG))
- nHEX  out  NDIG*8  active-low segments; digit d at [8d+7:8d], bit 7 = DP, bits 6:0 = g..a; digit 0 rightmost

## Operation
- **Display word.** The source word is live DIN when FREEZE=0, else a snapshot register.
  - The snapshot captures all CH*W bits on the cycle FREEZE goes 0→1.
  - Navigation operates on the snapshot while frozen.
- **Page contents.** Page p shows nibbles p*NDIG … p*NDIG+NDIG-1 of the selected word. Nibble positions ≥ W/4 (padding) are always blank (8'hFF).
- **Blanking.** With BLANK=1, digit i is blank if its nibble and every more-significant nibble of the whole word are zero. Nibble 0 is never blanked.
- **DP.** DP is off on every digit except digit NDIG-1, which is lit while FREEZE=1.
- **NEXT_PG.** Sets page ← page+1, wrapping P-1→0.
- **NEXT_CH.** Sets channel ← channel+1, wrapping CH-1→0, and resets page to 0.
- **Simultaneous NEXT_CH and NEXT_PG.** NEXT_CH wins; page becomes 0.
- **Auto mode (MODE=1).** A counter counts 0…AUTO_DIV-1. On the terminal count it issues one internal step:
  - page+1;
  - if page was P-1: page←0 and channel+1 (wrapping).
- **Buttons in auto mode.** Still act. A button pulse in the same cycle as the terminal count wins, the internal step is dropped, and the counter restarts at 0.
- **Counter resets.** Any MODE change or any button pulse clears the counter.
- **Channel count of 1.** If CH=1, NEXT_CH only resets the page.

## Timing
- Reset state (RST low, asynchronous):
  - nHEX = all ones (all segments off);
  - CH_IDX = 0, PAGE_IDX = 0;
  - auto counter = 0, snapshot = 0, FREEZE edge detector = 0.
- After RST releases, nHEX reflects the current state at the first rising edge.
- nHEX is registered; latency from DIN/BLANK/FREEZE/index change to nHEX is 1 cycle.
- CH_IDX/PAGE_IDX update at the edge following the pulse; nHEX shows the new page one cycle later (2 cycles pulse→pixels).
- In auto mode, steps occur every AUTO_DIV cycles with no button activity.
- Reset mid-scroll aborts immediately; no step is pending after release.

## Structure
- Shared package `hex_pkg`:
  - 16-entry active-low segment constant (0→7'h40 … F→7'h0E, g..a order);
  - page-count function ceil(W/(4*NDIG));
  - index-width function max(1,$clog2(n)).
- One sub-module `seg7_enc`: combinational nibble + blank + dp → 8-bit active-low code, instantiated NDIG times.
- Navigation state, auto counter, snapshot and blanking-prefix logic live in `hex_pager`.

## Test plan
Parameters for all scenarios: NDIG=4, CH=2, W=32, AUTO_DIV=8; ch0=32'h0000_1234, ch1=32'hDEAD_BEEF.

1. **Reset and first page.** Hold RST low → nHEX=32'hFFFF_FFFF, indices 0. Release with BLANK=0 → after 1 edge nHEX={F9,A4,B0,99} ("1234").
2. **Paging and blanking.** NEXT_PG → PAGE_IDX=1, nHEX=32'hC0C0_C0C0. With BLANK=1 → 32'hFFFF_FFFF. A second NEXT_PG wraps to page 0. With ch0=32'h5, BLANK=1, page 0 → {FF,FF,FF,92}.
3. **Channel change with simultaneous pulses.** NEXT_CH and NEXT_PG in the same cycle → CH_IDX=1, PAGE_IDX=0, nHEX={83,86,86,8E} ("BEEF").
4. **Auto-scroll.** MODE=1 → page steps every 8 cycles: ch0p0→ch0p1→ch1p0→ch1p1→ch0p0. A NEXT_PG on the terminal-count cycle yields exactly one step and restarts the 8-cycle interval.
5. **Freeze.** Raise FREEZE on ch0 page 0, then change ch0 to 32'h9999_9999 → nHEX stays {79,A4,B0,99} (DP lit on digit 3). Drop FREEZE → 1 cycle later {99,99,99,99}.
6. **Reset mid-operation.** Pulse RST low in auto mode at ch1p1 → outputs blank and indices 0 asynchronously. After release, the first step occurs exactly 8 cycles later.
